// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
// Holds the FSM state enum and the beat counter width.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int burst_max = 15;
  localparam int cw        = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports: req/mask (candidates), last_winner (search starts one above),
// pick (one-hot winner), valid (any candidate found).
module rr_pick #(
  parameter int nreq = 4,
  parameter int iw   = 2
) (
  input  logic [nreq-1:0] req,
  input  logic [nreq-1:0] mask,
  input  logic [iw-1:0]   last_winner,
  output logic [nreq-1:0] pick,
  output logic            valid
);

  logic [nreq-1:0] cand;

  assign cand = req & mask;

  // Two passes: indices above the last winner first, then wrap to 0.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int i = 0; i < nreq; i++) begin
      if (!valid && cand[i] && (i > int'(last_winner))) begin
        pick[i] = 1'b1;
        valid   = 1'b1;
      end
    end
    for (int i = 0; i < nreq; i++) begin
      if (!valid && cand[i] && (i <= int'(last_winner))) begin
        pick[i] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among nreq requesters.
// Ports: clk, rst (sync, active-low), req, req_data (packed per requester),
// full, gnt (registered one-hot), wr_en, data_out, busy.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int width = 8,
  parameter int nreq  = 4,
  parameter int burst = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [nreq-1:0]       req,
  input  logic [nreq*width-1:0] req_data,
  input  logic                  full,
  output logic [nreq-1:0]       gnt,
  output logic                  wr_en,
  output logic [width-1:0]      data_out,
  output logic                  busy
);

  localparam int iw = (nreq > 1) ? $clog2(nreq) : 1;
  localparam logic [cw-1:0] last_cnt = cw'(burst - 1);

  state_t          state, state_nx;
  logic [nreq-1:0] gnt_q, gnt_nx;
  logic [nreq-1:0] mask, pick;
  logic            pick_vld;
  logic [cw-1:0]   cnt, cnt_nx;
  logic [iw-1:0]   lw, lw_nx, pick_idx;
  logic            own_req, accept, rel;
  logic [width-1:0] dmux;

  // The releasing owner is excluded so a lone requester that used up
  // its burst goes through IDLE before winning again.
  assign mask = (state == OWN) ? ~gnt_q : '1;

  rr_pick #(
    .nreq(nreq),
    .iw  (iw)
  ) u_pick (
    .req        (req),
    .mask       (mask),
    .last_winner(lw),
    .pick       (pick),
    .valid      (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < nreq; i++) begin
      if (pick[i]) pick_idx = iw'(i);
    end
  end

  assign own_req = |(gnt_q & req);
  assign accept  = own_req & ~full;
  assign rel     = (state == OWN) &&
                   (!own_req || (accept && cnt == last_cnt));

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt_q;
    cnt_nx   = cnt;
    lw_nx    = lw;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        gnt_nx = '0;
        if (pick_vld) begin
          state_nx = OWN;
          gnt_nx   = pick;
          lw_nx    = pick_idx;
        end
      end
      OWN: begin
        if (rel) begin
          cnt_nx = '0;
          if (pick_vld) begin
            gnt_nx = pick;
            lw_nx  = pick_idx;
          end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
          end
        end else if (accept) begin
          cnt_nx = cnt + cw'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt_q <= '0;
      cnt   <= '0;
      lw    <= iw'(nreq - 1);
    end else begin
      state <= state_nx;
      gnt_q <= gnt_nx;
      cnt   <= cnt_nx;
      lw    <= lw_nx;
    end
  end

  always_comb begin
    dmux = '0;
    for (int i = 0; i < nreq; i++) begin
      if (gnt_q[i]) dmux = req_data[i*width +: width];
    end
  end

  // Gated by rst so nothing is written while reset is held.
  assign gnt      = gnt_q;
  assign wr_en    = accept & rst;
  assign data_out = rst ? dmux : '0;
  assign busy     = rst & (state == OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Per-cycle expected grants/writes plus an in-order write scoreboard.
module tb_fifo_wr_arbiter;

  localparam int width = 8;
  localparam int nreq  = 4;
  localparam int burst = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [nreq-1:0]       req;
  logic [nreq*width-1:0] req_data;
  logic                  full;
  logic [nreq-1:0]       gnt;
  logic                  wr_en;
  logic [width-1:0]      data_out;
  logic                  busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] dat [4];
  logic [7:0] sb [$];
  logic [7:0] sb_exp;

  always #5 clk = ~clk;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  fifo_wr_arbiter #(
    .width(width),
    .nreq (nreq),
    .burst(burst)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .full    (full),
    .gnt     (gnt),
    .wr_en   (wr_en),
    .data_out(data_out),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write must match the next word the model expects, in order.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      sb_exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk("sb_word", 32'(data_out), 32'(sb_exp));
    end
  end

  // One cycle: drive at edge+1, check at edge+3, advance model after edge.
  task automatic step(input string tag, input logic [3:0] r,
                      input logic f, input logic [3:0] eg,
                      input logic ew, input logic eb);
    int k;
    logic [7:0] ed;
    req  = r;
    full = f;
    #2;
    k = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) k = i;
    ed = (eg == 4'h0) ? 8'h00 : dat[k];
    chk({tag, ".gnt"},  32'(gnt),      32'(eg));
    chk({tag, ".wr"},   32'(wr_en),    32'(ew));
    chk({tag, ".busy"}, 32'(busy),     32'(eb));
    chk({tag, ".dout"}, 32'(data_out), 32'(ed));
    if (ew) sb.push_back(ed);
    @(posedge clk);
    #1;
    if (ew) dat[k] = dat[k] + 8'h01;
  endtask

  task automatic do_reset(input string tag);
    rst  = 1'b0;
    req  = '0;
    full = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".gnt"},  32'(gnt),      32'h0);
    chk({tag, ".wr"},   32'(wr_en),    32'h0);
    chk({tag, ".busy"}, 32'(busy),     32'h0);
    chk({tag, ".dout"}, 32'(data_out), 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 8'(((i + 1) << 4));
    rst  = 1'b0;
    req  = '0;
    full = 1'b0;

    // Lone requester: 4 beats, one IDLE cycle, re-grant.
    do_reset("rst1");
    step("s1c0", 4'b0001, 0, 4'b0000, 0, 0);
    for (int b = 0; b < 4; b++)
      step("s1own", 4'b0001, 0, 4'b0001, 1, 1);
    step("s1c5", 4'b0001, 0, 4'b0000, 0, 0);
    step("s1c6", 4'b0001, 0, 4'b0001, 1, 1);
    step("s1c7", 4'b0000, 0, 4'b0001, 0, 1);
    step("s1c8", 4'b0000, 0, 4'b0000, 0, 0);

    // All requesting: rotation with no gap between owners.
    do_reset("rst2");
    step("s2c0", 4'b1111, 0, 4'b0000, 0, 0);
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 4; b++)
        step("s2rr", 4'b1111, 0, 4'(1 << (g % 4)), 1, 1);
    step("s2drop", 4'b0000, 0, 4'b0010, 0, 1);
    step("s2idle", 4'b0000, 0, 4'b0000, 0, 0);

    // Stall by full mid-burst: grant held, then the remaining 2 beats.
    do_reset("rst3");
    step("s3c0", 4'b0001, 0, 4'b0000, 0, 0);
    step("s3b1", 4'b0001, 0, 4'b0001, 1, 1);
    step("s3b2", 4'b0001, 0, 4'b0001, 1, 1);
    for (int s = 0; s < 5; s++)
      step("s3full", 4'b0001, 1, 4'b0001, 0, 1);
    step("s3b3", 4'b0001, 0, 4'b0001, 1, 1);
    step("s3b4", 4'b0001, 0, 4'b0001, 1, 1);
    step("s3rel", 4'b0000, 0, 4'b0000, 0, 0);
    step("s3idle", 4'b0000, 0, 4'b0000, 0, 0);

    // Owner 2 drops after 1 beat; owner 3 then gets a full fresh burst.
    do_reset("rst4");
    step("s4c0", 4'b0100, 0, 4'b0000, 0, 0);
    step("s4c1", 4'b1100, 0, 4'b0100, 1, 1);
    step("s4c2", 4'b1000, 0, 4'b0100, 0, 1);
    for (int b = 0; b < 4; b++)
      step("s4own3", 4'b1000, 0, 4'b1000, 1, 1);
    step("s4c7", 4'b0000, 0, 4'b0000, 0, 0);

    // Reset during a burst of owner 1.
    do_reset("rst5");
    step("s5c0", 4'b0010, 0, 4'b0000, 0, 0);
    step("s5c1", 4'b0010, 0, 4'b0010, 1, 1);
    step("s5c2", 4'b0010, 0, 4'b0010, 1, 1);
    rst = 1'b0;
    req = 4'b0010;
    #2;
    chk("s5rst.wr",   32'(wr_en),    32'h0);
    chk("s5rst.busy", 32'(busy),     32'h0);
    chk("s5rst.dout", 32'(data_out), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("s5c4", 4'b0011, 0, 4'b0000, 0, 0);
    step("s5c5", 4'b0011, 0, 4'b0001, 1, 1);
    step("s5c6", 4'b0000, 0, 4'b0001, 0, 1);
    step("s5c7", 4'b0000, 0, 4'b0000, 0, 0);

    chk("sb_left", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
